// File: rtl/glb_arb_pkg.sv
// Shared types and helpers for the GLB port-1 arbiter.
// Holds the FSM state encoding and a one-hot-to-index helper.
package glb_arb_pkg;

    localparam int unsigned MAX_REQ = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } arb_state_e;

    // Callers pass a zero-extended one-hot vector. Any set bits are OR-ed together.
    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker. It returns the first set request at or above ptr,
// searching upward and wrapping around.
module rr_priority_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             any
);

    logic [N-1:0] rot_req;
    logic [N-1:0] rot_win;

    // Rotate so that ptr lands on bit 0, isolate the lowest set bit, then rotate back.
    always_comb begin
        rot_req = N'({req, req} >> ptr);
        rot_win = rot_req & ~(rot_req - 1'b1);
        winner  = N'(({rot_win, rot_win} << ptr) >> N);
        any     = |req;
    end

endmodule

// File: rtl/glb_port_arbiter.sv
// Round-robin arbiter for GLB RAM port 1 with burst ownership, zero-bubble handover,
// a burst cap and read-return strobes that go back to the requester that issued the read.
module glb_port_arbiter
    import glb_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr1,
    output logic [DATA_WIDTH-1:0]          ram_di,
    input  logic [DATA_WIDTH-1:0]          ram_do1,
    output logic [NUM_REQ-1:0]             rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CAP_M1   = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0]  hold_addr_q;
    logic [DATA_WIDTH-1:0]  hold_di_q;

    logic                   own_valid, own_we, own_last;
    logic [ADDR_WIDTH-1:0]  own_addr;
    logic [DATA_WIDTH-1:0]  own_di;
    logic [MAX_REQ-1:0]     grant_ext;
    logic [IDX_W-1:0]       owner_idx, next_ptr, pick_ptr;
    logic [NUM_REQ-1:0]     pick_winner;
    logic                   pick_any;
    logic                   in_own, beat, cap_hit, release_own;

    // Owner mux. An AND-OR over the one-hot grant yields all zeros when idle.
    always_comb begin
        own_valid = 1'b0;
        own_we    = 1'b0;
        own_last  = 1'b0;
        own_addr  = '0;
        own_di    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) begin
                own_valid = req_valid[i];
                own_we    = req_we[i];
                own_last  = req_last[i];
                own_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_di    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        grant_ext                = '0;
        grant_ext[NUM_REQ-1:0]   = grant_q;
    end

    assign owner_idx = IDX_W'(onehot_to_idx(grant_ext));
    assign next_ptr  = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;
    assign in_own    = (state_q == StOwn);

    // The handover search starts just past the current owner, so a releasing owner
    // ranks last and wins again only when it is the sole requester.
    assign pick_ptr  = in_own ? next_ptr : ptr_q;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (pick_ptr),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign beat        = en & in_own & own_valid;
    assign cap_hit     = (cnt_q == CAP_M1);
    assign release_own = (en & in_own & ~own_valid) | (beat & (own_last | cap_hit));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        if (en) begin
            rd_valid_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        state_d = StOwn;
                        grant_d = pick_winner;
                        cnt_d   = '0;
                    end
                end
                StOwn: begin
                    if (beat) begin
                        cnt_d = cnt_q + 1'b1;
                        if (!own_we) begin
                            rd_valid_d = grant_q;
                        end
                    end
                    if (release_own) begin
                        ptr_d = next_ptr;
                        cnt_d = '0;
                        if (pick_any) begin
                            grant_d = pick_winner;
                        end else begin
                            state_d = StIdle;
                            grant_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rd_valid_q  <= '0;
            hold_addr_q <= '0;
            hold_di_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            if (en && in_own) begin
                hold_addr_q <= own_addr;
                hold_di_q   <= own_di;
            end
        end
    end

    assign req_ready = en ? grant_q : '0;
    assign ram_we    = beat & own_we;
    assign ram_addr1 = in_own ? own_addr : hold_addr_q;
    assign ram_di    = in_own ? own_di : hold_di_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = ram_do1;
    assign grant     = grant_q;
    assign busy      = in_own;

endmodule
